// File: rtl/ws2812_pkg.sv
// Shared constants for the WS2812 line encoder: 50 MHz timing defaults,
// frame geometry and the encoder state codes.
package ws2812_pkg;

  // Bit and latch timing in clock cycles at 50 MHz
  localparam int unsigned T0H_CYC_50M   = 20;     // 0.40 us
  localparam int unsigned T1H_CYC_50M   = 40;     // 0.80 us
  localparam int unsigned BIT_CYC_50M   = 63;     // 1.26 us
  localparam int unsigned RESET_CYC_50M = 15000;  // 300 us

  // One LED takes a GRB triplet of 8-bit channels
  localparam int unsigned BITS_PER_LED = 24;

  // Encoder states
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StHigh  = 2'd1;
  localparam logic [1:0] StLow   = 2'd2;
  localparam logic [1:0] StLatch = 2'd3;

endpackage

// File: rtl/ws2812_timer.sv
// Loadable down counter with terminal-count flag. It parks at zero rather
// than wrapping, so tc_o stays high until the next load.
module ws2812_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Load takes priority; otherwise count down and hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, synchronously cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/ws2812_encoder.sv
// WS2812 single-wire encoder. Turns a stream of colour bits into fixed-period
// high/low slots, then holds the line low for the latch time after a full
// frame. A single shared timer sequences the high, low, latch and stall times.
module ws2812_encoder
  import ws2812_pkg::*;
#(
  parameter int unsigned T0H_CYC   = T0H_CYC_50M,
  parameter int unsigned T1H_CYC   = T1H_CYC_50M,
  parameter int unsigned BIT_CYC   = BIT_CYC_50M,
  parameter int unsigned RESET_CYC = RESET_CYC_50M,
  parameter int unsigned NUM_LEDS  = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   bit_in,
  input  logic                                   bit_valid,
  output logic                                   bit_ready,
  output logic                                   dout,
  output logic                                   busy,
  output logic                                   frame_done,
  output logic                                   underrun,
  output logic                                   frame_abort,
  output logic [$clog2(NUM_LEDS*BITS_PER_LED)-1:0] bit_idx_dbg
);

  localparam int unsigned TOTAL_BITS = NUM_LEDS * BITS_PER_LED;
  localparam int unsigned IDX_W      = $clog2(TOTAL_BITS);
  localparam int unsigned CNT_W      = $clog2(RESET_CYC + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_BITS - 1);

  // Timer load values are length-1 because the terminal cycle is the zero count
  localparam logic [CNT_W-1:0] T0H_LD = CNT_W'(T0H_CYC - 1);
  localparam logic [CNT_W-1:0] T1H_LD = CNT_W'(T1H_CYC - 1);
  localparam logic [CNT_W-1:0] T0L_LD = CNT_W'(BIT_CYC - T0H_CYC - 1);
  localparam logic [CNT_W-1:0] T1L_LD = CNT_W'(BIT_CYC - T1H_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RESET_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic             bit_q, bit_d;
  logic [IDX_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             dout_q;
  logic             underrun_q, underrun_d;
  logic             frame_done_c, frame_abort_c;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_tc;
  logic             transfer;

  ws2812_timer #(
    .Width (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  // Ready depends only on state and counters so upstream can't form a loop
  always_comb begin
    bit_ready = 1'b0;
    if (state_q == StIdle) begin
      bit_ready = 1'b1;
    end else if (state_q == StLow && tmr_tc && bit_cnt_q != LAST_IDX) begin
      bit_ready = 1'b1;
    end
  end

  assign transfer = bit_valid & bit_ready;

  // Next-state, bit latch, frame counter and timer load decisions
  always_comb begin
    state_d       = state_q;
    bit_d         = bit_q;
    bit_cnt_d     = bit_cnt_q;
    underrun_d    = 1'b0;
    frame_done_c  = 1'b0;
    frame_abort_c = 1'b0;
    tmr_load      = 1'b0;
    tmr_val       = RST_LD;
    case (state_q)
      StIdle: begin
        // Mid-frame stall: the timer was loaded with the latch time on entry
        if (bit_cnt_q != '0 && tmr_tc) begin
          frame_abort_c = 1'b1;
          bit_cnt_d     = '0;
        end
        // A bit arriving on the abort cycle starts the fresh frame
        if (transfer) begin
          bit_d    = bit_in;
          state_d  = StHigh;
          tmr_load = 1'b1;
          tmr_val  = bit_in ? T1H_LD : T0H_LD;
        end
      end
      StHigh: begin
        if (tmr_tc) begin
          state_d  = StLow;
          tmr_load = 1'b1;
          tmr_val  = bit_q ? T1L_LD : T0L_LD;
        end
      end
      StLow: begin
        if (tmr_tc) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_IDX) begin
            state_d  = StLatch;
            tmr_load = 1'b1;
            tmr_val  = RST_LD;
          end else if (transfer) begin
            bit_d    = bit_in;
            state_d  = StHigh;
            tmr_load = 1'b1;
            tmr_val  = bit_in ? T1H_LD : T0H_LD;
          end else begin
            state_d    = StIdle;
            underrun_d = 1'b1;
            tmr_load   = 1'b1;
            tmr_val    = RST_LD;
          end
        end
      end
      StLatch: begin
        if (tmr_tc) begin
          frame_done_c = 1'b1;
          bit_cnt_d    = '0;
          state_d      = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset drops the line low on the next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      bit_q      <= 1'b0;
      bit_cnt_q  <= '0;
      dout_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      bit_cnt_q  <= bit_cnt_d;
      dout_q     <= (state_d == StHigh);
      underrun_q <= underrun_d;
    end
  end

  assign dout        = dout_q;
  assign busy        = (state_q != StIdle);
  assign underrun    = underrun_q;
  // Terminal-cycle pulses are suppressed while reset is being applied
  assign frame_done  = frame_done_c & ~rst;
  assign frame_abort = frame_abort_c & ~rst;
  assign bit_idx_dbg = bit_cnt_q;

endmodule

// File: tb/tb_ws2812_encoder.sv
// Directed bench for ws2812_encoder with small timing parameters. Expected
// pulse widths are queued when a bit is handed over and compared when the
// corresponding high pulse on dout ends.
module tb_ws2812_encoder;

  localparam int T0H  = 2;
  localparam int T1H  = 4;
  localparam int BITC = 6;
  localparam int RSTC = 10;
  localparam int NLED = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic       dout;
  logic       busy;
  logic       frame_done;
  logic       underrun;
  logic       frame_abort;
  logic [4:0] bit_idx_dbg;

  ws2812_encoder #(
    .T0H_CYC   (T0H),
    .T1H_CYC   (T1H),
    .BIT_CYC   (BITC),
    .RESET_CYC (RSTC),
    .NUM_LEDS  (NLED)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .dout        (dout),
    .busy        (busy),
    .frame_done  (frame_done),
    .underrun    (underrun),
    .frame_abort (frame_abort),
    .bit_idx_dbg (bit_idx_dbg)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int exp_q[$];
  logic prev_dout = 1'b0;
  int hi_len = 0;
  int lo_len = 0;
  int last_hi = 0;
  int n_underrun = 0;
  int n_done = 0;
  int n_abort = 0;
  int cyc_underrun = 0;
  int cyc_abort = 0;

  task automatic check1(input string tag, input logic obs, input logic expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic checkn(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Advance one clock, sample just after the edge and run the pulse monitor
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (underrun === 1'b1) begin
      n_underrun++;
      cyc_underrun = cyc;
    end
    if (frame_done === 1'b1) n_done++;
    if (frame_abort === 1'b1) begin
      n_abort++;
      cyc_abort = cyc;
    end
    if (dout === 1'b1 && prev_dout !== 1'b1) begin
      if (last_hi != 0) checkn("slot_gap", lo_len, BITC - last_hi);
      hi_len = 1;
    end else if (dout === 1'b1) begin
      hi_len++;
    end else if (prev_dout === 1'b1) begin
      if (exp_q.size() == 0) checkn("unexpected_pulse", hi_len, 0);
      else checkn("pulse_width", hi_len, exp_q.pop_front());
      last_hi = hi_len;
      lo_len  = 1;
    end else begin
      lo_len++;
    end
    prev_dout = dout;
  endtask

  // Hold valid with noisy data until ready, then hand over bit b
  task automatic send_bit(input logic b);
    int w;
    w = 0;
    bit_valid = 1'b1;
    while (bit_ready !== 1'b1 && w < 50) begin
      bit_in = 1'($urandom_range(0, 1));
      tick();
      w++;
    end
    if (bit_ready !== 1'b1) begin
      check1("ready_timeout", bit_ready, 1'b1);
      bit_valid = 1'b0;
    end else begin
      bit_in = b;
      exp_q.push_back(b ? T1H : T0H);
      tick();
    end
  endtask

  // From HIGH cycle 1 of the last bit: slot, latch, frame_done, back to IDLE
  task automatic finish_frame();
    int d0;
    d0 = n_done;
    for (int i = 1; i <= BITC + RSTC; i++) begin
      if (i > 1) tick();
      check1("ready_low_end", bit_ready, 1'b0);
      check1("frame_done_at", frame_done, 1'(i == BITC + RSTC));
      if (i > BITC) check1("latch_low", dout, 1'b0);
      bit_in = 1'($urandom_range(0, 1));
      if (i == BITC + RSTC) bit_valid = 1'b0;
    end
    tick();
    check1("idle_ready", bit_ready, 1'b1);
    checkn("idx_cleared", 32'(bit_idx_dbg), 0);
    checkn("one_done", n_done - d0, 1);
    check1("done_gone", frame_done, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bit_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int u0;
    int a0;
    int d0;
    rst = 1'b1;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    tick();
    tick();
    check1("rst_dout", dout, 1'b0);
    check1("rst_underrun", underrun, 1'b0);
    check1("rst_done", frame_done, 1'b0);
    check1("rst_abort", frame_abort, 1'b0);
    rst = 1'b0;
    tick();
    check1("rst_ready", bit_ready, 1'b1);
    check1("rst_busy", busy, 1'b0);
    checkn("rst_idx", 32'(bit_idx_dbg), 0);

    // Single '1' then silence: high 1-4, low 5-6, underrun 7, abort 16
    last_hi = 0;
    send_bit(1'b1);
    bit_valid = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      if (k > 1) tick();
      if (k <= 7) check1("b1_dout", dout, 1'(k <= 4));
      check1("b1_underrun", underrun, 1'(k == 7));
      if (k == 7) checkn("b1_idx", 32'(bit_idx_dbg), 1);
      if (k >= 7) check1("b1_abort", frame_abort, 1'(k == 16));
    end
    checkn("b1_idx_abort", 32'(bit_idx_dbg), 0);

    // Single '0': high 2, low 4
    last_hi = 0;
    send_bit(1'b0);
    bit_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) tick();
      check1("b0_dout", dout, 1'(k <= 2));
      check1("b0_underrun", underrun, 1'(k == 7));
    end
    do_reset();

    // Full frame of alternating bits, valid held high
    u0 = n_underrun;
    a0 = n_abort;
    last_hi = 0;
    for (int i = 0; i < 24; i++) send_bit(1'(i % 2 == 0));
    finish_frame();
    checkn("alt_no_underrun", n_underrun - u0, 0);
    checkn("alt_no_abort", n_abort - a0, 0);

    // Five bits then stall until abort, then a complete frame
    u0 = n_underrun;
    a0 = n_abort;
    last_hi = 0;
    for (int i = 0; i < 5; i++) send_bit(1'(i % 3 == 0));
    bit_valid = 1'b0;
    repeat (25) tick();
    checkn("stall_underrun", n_underrun - u0, 1);
    checkn("stall_abort", n_abort - a0, 1);
    checkn("stall_len", cyc_abort - cyc_underrun, RSTC - 1);
    checkn("stall_idx", 32'(bit_idx_dbg), 0);
    u0 = n_underrun;
    last_hi = 0;
    for (int i = 0; i < 24; i++) send_bit(1'(((i * 7) % 5) < 2));
    finish_frame();
    checkn("frame2_no_underrun", n_underrun - u0, 0);

    // Reset during HIGH of bit 3: pulse truncated to its first cycle
    last_hi = 0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    exp_q[exp_q.size() - 1] = 1;
    u0 = n_underrun;
    a0 = n_abort;
    d0 = n_done;
    do_reset();
    check1("mid_rst_dout", dout, 1'b0);
    check1("mid_rst_ready", bit_ready, 1'b1);
    checkn("mid_rst_idx", 32'(bit_idx_dbg), 0);
    repeat (15) tick();
    checkn("mid_rst_underrun", n_underrun - u0, 0);
    checkn("mid_rst_abort", n_abort - a0, 0);
    checkn("mid_rst_done", n_done - d0, 0);
    check1("mid_rst_idle", busy, 1'b0);
    checkn("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
